// File: rtl/risc_loader_pkg.sv
// Shared definitions for the VERI_RISC program loader: FSM states, memory geometry,
// CPU opcode constants and the length-byte clamp helper.
package risc_loader_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 32;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CPURST,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    // Index of the final byte to load; lengths beyond the memory depth fill it completely.
    function automatic logic [ADDR_W-1:0] last_index(input logic [DATA_W-1:0] len);
        if (len > DATA_W'(MEM_DEPTH))
            return ADDR_W'(MEM_DEPTH - 1);
        else
            return ADDR_W'(len - 8'd1);
    endfunction

endpackage

// File: rtl/risc_loader_cnt.sv
// Saturating run-cycle counter with synchronous clear and count enable.
module risc_loader_cnt
    import risc_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/risc_loader.sv
// Streams a length-prefixed program into VERI_RISC memory, resets the CPU, then times
// its run until halt or TIMEOUT.
module risc_loader
    import risc_loader_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd1000,
    parameter int          RST_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycles
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYC - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] k, last_k;
    logic [7:0]        rst_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic              take_len, take_byte, cnt_clr, cnt_en, fin_halt, fin_timeout;

    risc_loader_cnt u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (run_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        cpu_rst     = 1'b0;
        done        = 1'b0;
        take_len    = 1'b0;
        take_byte   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        fin_halt    = 1'b0;
        fin_timeout = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                in_ready = 1'b1;
                cpu_rst  = (state == ST_IDLE);
                done     = (state == ST_DONE);
                if (in_valid) begin
                    take_len  = 1'b1;
                    state_nxt = (in_data == '0) ? ST_CPURST : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                cpu_rst  = 1'b1;
                if (in_valid) begin
                    take_byte = 1'b1;
                    if (k == last_k)
                        state_nxt = ST_CPURST;
                end
            end
            ST_CPURST: begin
                cpu_rst = 1'b1;
                cnt_clr = 1'b1;
                if (rst_cnt == RST_LAST)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A halt seen in the same cycle as the limit takes priority.
                if (cpu_halt) begin
                    fin_halt  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (run_cnt >= TIMEOUT) begin
                    fin_timeout = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k         <= '0;
            last_k    <= '0;
            rst_cnt   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            timed_out <= 1'b0;
            cycles    <= '0;
        end else begin
            mem_we  <= take_byte;
            rst_cnt <= (state == ST_CPURST) ? rst_cnt + 8'd1 : 8'd0;
            if (take_len) begin
                last_k    <= last_index(in_data);
                k         <= '0;
                timed_out <= 1'b0;
                cycles    <= '0;
            end
            if (take_byte) begin
                mem_addr  <= k;
                mem_wdata <= in_data;
                k         <= k + 1'b1;
            end
            if (fin_halt) begin
                cycles    <= run_cnt;
                timed_out <= 1'b0;
            end
            if (fin_timeout) begin
                cycles    <= TIMEOUT;
                timed_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_risc_loader.sv
// Scoreboard bench for risc_loader: two instances (TIMEOUT 20 and 10) share stimulus,
// each driven by a CPU stub that halts H cycles after cpu_rst falls.
module tb_risc_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;

    logic        in_ready_a, mem_we_a, cpu_rst_a, cpu_halt_a, done_a, timed_out_a;
    logic [4:0]  mem_addr_a;
    logic [7:0]  mem_wdata_a;
    logic [15:0] cycles_a;
    logic        in_ready_b, mem_we_b, cpu_rst_b, cpu_halt_b, done_b, timed_out_b;
    logic [4:0]  mem_addr_b;
    logic [7:0]  mem_wdata_b;
    logic [15:0] cycles_b;

    int total = 0;
    int bad = 0;
    int stub_h = 100000;
    int sc_a = 0;
    int sc_b = 0;

    logic [12:0] wq[$];
    logic [16:0] rq_a[$];
    logic [16:0] rq_b[$];
    logic [7:0]  prog[64];
    int          gaps[64];

    always #5 clk = ~clk;

    risc_loader #(.TIMEOUT(16'd20), .RST_CYC(2)) u_dut (
        .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .cpu_rst(cpu_rst_a),
        .cpu_halt(cpu_halt_a), .done(done_a), .timed_out(timed_out_a), .cycles(cycles_a)
    );

    risc_loader #(.TIMEOUT(16'd10), .RST_CYC(2)) u_dut10 (
        .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .cpu_rst(cpu_rst_b),
        .cpu_halt(cpu_halt_b), .done(done_b), .timed_out(timed_out_b), .cycles(cycles_b)
    );

    // CPU stubs
    always @(posedge clk) begin
        if (cpu_rst_a) sc_a <= 0; else if (sc_a < 1000000) sc_a <= sc_a + 1;
        if (cpu_rst_b) sc_b <= 0; else if (sc_b < 1000000) sc_b <= sc_b + 1;
    end
    assign cpu_halt_a = !cpu_rst_a && (sc_a >= stub_h);
    assign cpu_halt_b = !cpu_rst_b && (sc_b >= stub_h);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: memory writes, run results, CPU reset pulse length
    logic       done_prev_a = 1'b0;
    logic       done_prev_b = 1'b0;
    int         cpurst_len = 0;
    logic [12:0] wexp;
    logic [16:0] rexp;

    always @(negedge clk) begin
        if (mem_we_a) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'({mem_addr_a, mem_wdata_a}), 32'hFFFF_FFFF);
            end else begin
                wexp = wq.pop_front();
                check("write_addr", 32'(mem_addr_a), 32'(wexp[12:8]));
                check("write_data", 32'(mem_wdata_a), 32'(wexp[7:0]));
            end
        end
        if (done_a && !done_prev_a) begin
            if (rq_a.size() == 0) begin
                check("unexpected_done_a", 32'(done_a), 32'd0);
            end else begin
                rexp = rq_a.pop_front();
                check("cycles_a", 32'(cycles_a), 32'(rexp[15:0]));
                check("timed_out_a", 32'(timed_out_a), 32'(rexp[16]));
            end
        end
        if (done_b && !done_prev_b) begin
            if (rq_b.size() == 0) begin
                check("unexpected_done_b", 32'(done_b), 32'd0);
            end else begin
                rexp = rq_b.pop_front();
                check("cycles_b", 32'(cycles_b), 32'(rexp[15:0]));
                check("timed_out_b", 32'(timed_out_b), 32'(rexp[16]));
            end
        end
        done_prev_a = done_a;
        done_prev_b = done_b;
        if (rst_n && cpu_rst_a && !in_ready_a) begin
            cpurst_len++;
        end else if (cpurst_len != 0) begin
            check("cpurst_len", 32'(cpurst_len), 32'd2);
            cpurst_len = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        int   budget;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        budget   = 0;
        forever begin
            ok = in_ready_a;
            @(posedge clk);
            if (ok) break;
            budget++;
            if (budget > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 0;
        @(negedge clk);
        while (!(done_a && done_b) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 500) check("done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        check("done_held", 32'(done_a), 32'd1);
        check("done_in_ready", 32'(in_ready_a), 32'd1);
        check("done_cpu_rst", 32'(cpu_rst_a), 32'd0);
    endtask

    task automatic do_run(input int n_len, input int n_bytes, input int h,
                          input int ca, input logic ta, input int cb, input logic tb);
        stub_h = h;
        rq_a.push_back({ta, 16'(ca)});
        rq_b.push_back({tb, 16'(cb)});
        send_byte(8'(n_len), 0);
        for (int i = 0; i < n_bytes; i++) begin
            wq.push_back({5'(i), prog[i]});
            send_byte(prog[i], gaps[i]);
        end
        wait_done();
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_mem_we", 32'(mem_we_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata_a), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst_a), 32'd1);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_timed_out", 32'(timed_out_a), 32'd0);
        check("rst_cycles", 32'(cycles_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single zero byte, halt after 3
        prog[0] = 8'h00; gaps[0] = 0;
        do_run(1, 1, 3, 3, 1'b0, 3, 1'b0);

        // three bytes with input gaps
        prog[0] = 8'hE2; prog[1] = 8'hE2; prog[2] = 8'h00;
        gaps[0] = 0; gaps[1] = 2; gaps[2] = 5;
        do_run(3, 3, 4, 4, 1'b0, 4, 1'b0);

        // rerun without halting: both instances time out
        do_run(0, 0, 100000, 20, 1'b1, 10, 1'b1);

        // rerun, halt after 5
        do_run(0, 0, 5, 5, 1'b0, 5, 1'b0);

        // halt coincides with the TIMEOUT=10 limit
        do_run(0, 0, 10, 10, 1'b0, 10, 1'b0);

        // reset while byte 2 of 4 is offered
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44;
        gaps[0] = 0; gaps[1] = 0; gaps[2] = 0; gaps[3] = 0;
        stub_h = 3;
        send_byte(8'd4, 0);
        for (int i = 0; i < 2; i++) begin
            wq.push_back({5'(i), prog[i]});
            send_byte(prog[i], 0);
        end
        @(posedge clk);
        @(negedge clk);
        in_data  = prog[2];
        in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("async_in_ready", 32'(in_ready_a), 32'd1);
        check("async_cpu_rst", 32'(cpu_rst_a), 32'd1);
        check("async_mem_we", 32'(mem_we_a), 32'd0);
        check("async_mem_addr", 32'(mem_addr_a), 32'd0);
        check("async_done", 32'(done_a), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_run(4, 4, 3, 3, 1'b0, 3, 1'b0);

        // oversize length fills all 32 locations
        for (int i = 0; i < 32; i++) begin
            prog[i] = 8'(i * 7 + 1);
            gaps[i] = 0;
        end
        do_run(40, 32, 2, 2, 1'b0, 2, 1'b0);

        repeat (5) @(negedge clk);
        check("writes_left", 32'(wq.size()), 32'd0);
        check("results_left_a", 32'(rq_a.size()), 32'd0);
        check("results_left_b", 32'(rq_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/risc_loader.md
RISC_LOADER -- requirements
Module: risc_loader

Interface
REQ-001 Parameter TIMEOUT, default 16'd1000: maximum run cycles before abort.
REQ-002 Parameter RST_CYC, default 2: cycles cpu_rst is held high before a run.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  8  program byte stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts in_data; transfer = in_valid & in_ready.
REQ-008 mem_addr  output  5  CPU memory write address.
REQ-009 mem_wdata  output  8  CPU memory write data.
REQ-010 mem_we  output  1  CPU memory write strobe, one cycle per byte.
REQ-011 cpu_rst  output  1  active-high reset to VERI_RISC.
REQ-012 cpu_halt  input  1  halt from VERI_RISC.
REQ-013 done  output  1  run finished; held until next load begins.
REQ-014 timed_out  output  1  run aborted by TIMEOUT; valid while done=1.
REQ-015 cycles  output  16  run cycle count; valid while done=1.

Function
REQ-016 States: IDLE, LOAD, CPURST, RUN, DONE.
- IDLE: in_ready=1. A transfer takes in_data as length N and clears done, timed_out, cycles.
- N=1..32: load N bytes, go LOAD. N=0: skip load, go CPURST and rerun the current memory. N>32: treated as 32.
REQ-017 LOAD: in_ready=1 and a byte counter k starts at 0.
- Each transfer registers mem_addr=k, mem_wdata=in_data, and mem_we=1 on the next cycle (latency 1).
- k increments per transfer. After the transfer with k=N-1, go CPURST.
- in_valid low stalls the load without limit; no bytes are lost or duplicated.
REQ-018 CPURST: in_ready=0, cpu_rst=1 for exactly RST_CYC cycles, then go RUN. The last mem_we pulse completes before cpu_rst deasserts.
REQ-019 RUN: cpu_rst=0 and in_ready=0. The counter starts at 0 and increments each cycle that cpu_halt=0.
- cpu_halt sampled 1: go DONE, cycles = counter, timed_out=0.
- counter = TIMEOUT with cpu_halt=0: go DONE, timed_out=1, cycles=TIMEOUT.
- cpu_halt and timeout in the same cycle: halt wins, timed_out=0.
REQ-020 DONE: done=1, cpu_rst=0 (CPU left halted), in_ready=1. A transfer is a new length byte and is handled exactly as in IDLE.
REQ-021 cpu_rst=1 in IDLE, LOAD and CPURST. The CPU never runs while memory is written.
REQ-022 mem_we=0 in every state except the cycle after a LOAD transfer.
REQ-023 The counter saturates and does not wrap. TIMEOUT is at most 16'hFFFF.

Reset
REQ-024 rst low, asynchronously:
- state goes to IDLE.
- outputs: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, timed_out=0, cycles=0.
REQ-025 Reset mid-LOAD or mid-RUN abandons the operation. Memory contents already written are not restored.
REQ-026 Deassertion takes effect at the first rising clk edge with rst high.

Structure
REQ-027 The shared package holds: state encoding, address width 5, data width 8, memory depth 32, and the VERI_RISC opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-028 One sub-module, risc_loader_cnt: 16-bit saturating run counter with clear and enable.
REQ-029 RTL stays in the range 120-400 lines. No memory is instantiated inside the loader.

Verification
REQ-030 Bench uses a CPU stub that raises cpu_halt H cycles after cpu_rst falls.
REQ-031 Load N=1, byte 8'h00, stub H=3:
- mem_we pulses once, addr 0, data 8'h00.
- cpu_rst high for 2 cycles.
- done=1, cycles=3, timed_out=0.
REQ-032 Load N=3 {8'hE2, 8'hE2, 8'h00} with in_valid gaps of 0, 2 and 5 cycles:
- exactly three writes, addr 0,1,2, in order, no duplicates.
REQ-033 Stub never halts, TIMEOUT=20: done=1, timed_out=1, cycles=20.
REQ-034 Length 0 after a prior load: no mem_we, straight to CPURST; halt after H=5 gives cycles=5.
REQ-035 rst low at LOAD byte 2 of 4:
- asynchronous return to IDLE, cpu_rst=1, mem_we=0.
- a fresh full load then completes correctly.
REQ-036 Stub halts on the same cycle the counter reaches TIMEOUT=10: timed_out=0, cycles=10.
